// File: rtl/rgby_pkg.sv
// rgby_pkg: shared color-nit widths, color encodings and serializer state encoding.
package rgby_pkg;
    localparam int NIT_WIDTH     = 2;
    localparam int WORD_WIDTH    = 12;
    localparam int NITS_PER_WORD = WORD_WIDTH / NIT_WIDTH;

    localparam logic [NIT_WIDTH-1:0] RED    = 2'd0;
    localparam logic [NIT_WIDTH-1:0] GREEN  = 2'd1;
    localparam logic [NIT_WIDTH-1:0] BLUE   = 2'd2;
    localparam logic [NIT_WIDTH-1:0] YELLOW = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } ser_state_e;
endpackage

// File: rtl/ram_color_serializer.sv
// ram_color_serializer: reads RAM words and streams them out as MSB-first color nits
// over a valid/ready handshake, one word per ADDR/LOAD/SHIFT pass.
module ram_color_serializer #(
    parameter int WORD_WIDTH = rgby_pkg::WORD_WIDTH,
    parameter int NIT_WIDTH  = rgby_pkg::NIT_WIDTH,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] startAddress,
    input  logic [ADDR_WIDTH:0]   wordCount,
    output logic [ADDR_WIDTH-1:0] readAddress,
    input  logic [WORD_WIDTH-1:0] readData,
    output logic [NIT_WIDTH-1:0]  color,
    output logic                  colorValid,
    input  logic                  colorReady,
    output logic                  busy,
    output logic                  done
);
    import rgby_pkg::*;

    localparam int NPW = WORD_WIDTH / NIT_WIDTH;
    localparam int NW  = (NPW > 1) ? $clog2(NPW) : 1;
    localparam int CW  = ADDR_WIDTH + 1;

    ser_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]         rem_q, rem_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [NW-1:0]         nit_q, nit_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  hs, last_nit, last_word;

    always_comb begin
        hs        = valid_q && colorReady;
        last_nit  = nit_q == NW'(NPW - 1);
        last_word = rem_q == CW'(1);
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        shift_d   = shift_q;
        nit_d     = nit_q;
        valid_d   = valid_q;
        case (state_q)
            S_IDLE: if (start) begin
                addr_d  = startAddress;
                rem_d   = wordCount;
                state_d = (wordCount == '0) ? S_DONE : S_ADDR;
            end
            S_ADDR: state_d = S_LOAD;
            S_LOAD: begin
                shift_d = readData;
                nit_d   = '0;
                valid_d = 1'b1;
                state_d = S_SHIFT;
            end
            S_SHIFT: if (hs) begin
                shift_d = shift_q << NIT_WIDTH;
                nit_d   = nit_q + NW'(1);
                // the final nit of a word closes it out and either finishes or fetches the next word
                if (last_nit) begin
                    valid_d = 1'b0;
                    rem_d   = rem_q - CW'(1);
                    state_d = last_word ? S_DONE : S_ADDR;
                    addr_d  = last_word ? addr_q : addr_q + ADDR_WIDTH'(1);
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_ADDR) || (state_d == S_LOAD) || (state_d == S_SHIFT);
        done_d = state_d == S_DONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            shift_q <= '0;
            nit_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            shift_q <= shift_d;
            nit_q   <= nit_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign readAddress = addr_q;
    assign color       = shift_q[WORD_WIDTH-1 -: NIT_WIDTH];
    assign colorValid  = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
endmodule
